// File: rtl/mosaic_mem_pkg.sv
// rtl/mosaic_mem_pkg.sv - shared codes, header layout and pack/unpack helpers for remote load/store
package mosaic_mem_pkg;

   localparam int HDR_XY_SZ     = 3;
   localparam int HDR_OFFSET_SZ = 12;

   // Packet type codes carried in the header code field
   localparam logic [2:0] MPUT   = 3'd0;
   localparam logic [2:0] MACK   = 3'd1;
   localparam logic [2:0] MDATA  = 3'd2;
   localparam logic [2:0] MGET   = 3'd3;
   localparam logic [2:0] QS     = 3'd4;
   localparam logic [2:0] QM     = 3'd5;
   localparam logic [2:0] MLOAD  = 3'd6;
   localparam logic [2:0] MSTORE = 3'd7;

   typedef struct packed {
      logic [2:0]                 rsvd;
      logic                       hl;
      logic [2:0]                 code;
      logic                       pt;
      logic [2*HDR_XY_SZ-1:0]     src;
      logic [HDR_OFFSET_SZ-1:0]   offset;
      logic [HDR_XY_SZ-1:0]       y_dest;
      logic [HDR_XY_SZ-1:0]       x_dest;
   } mem_hdr_t;

   function automatic logic [31:0] hdr_pack(
      input logic [2:0]               code,
      input logic [2*HDR_XY_SZ-1:0]   src,
      input logic [HDR_OFFSET_SZ-1:0] offset,
      input logic [HDR_XY_SZ-1:0]     y_dest,
      input logic [HDR_XY_SZ-1:0]     x_dest
   );
      mem_hdr_t h;
      h        = '0;
      h.code   = code;
      h.src    = src;
      h.offset = offset;
      h.y_dest = y_dest;
      h.x_dest = x_dest;
      return h;
   endfunction

   function automatic mem_hdr_t hdr_unpack(input logic [31:0] w);
      return mem_hdr_t'(w);
   endfunction

endpackage

// File: rtl/mem_rsp_fmt.sv
// rtl/mem_rsp_fmt.sv - combinational response-header builder for MDATA/MACK replies
module mem_rsp_fmt
   import mosaic_mem_pkg::*;
#(
   parameter int XY_SZ     = 3,
   parameter int OFFSET_SZ = 12
) (
   input  logic                   is_load_i,
   input  logic [2*XY_SZ-1:0]     self_id_i,
   input  logic [OFFSET_SZ-1:0]   offset_i,
   input  logic [2*XY_SZ-1:0]     src_i,
   output logic [31:0]            hdr_o
);

   // Reserved bits and hl are always sent as zero
   localparam int PAD = 28 - 4*XY_SZ - OFFSET_SZ;

   // Reply goes back to the requester: our id becomes the source, its id the destination
   always_comb begin
      hdr_o = {{PAD{1'b0}}, (is_load_i ? MDATA : MACK), 1'b0, self_id_i, offset_i, src_i};
   end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - target-side server for remote MLOAD/MSTORE packets
module mem_responder
   import mosaic_mem_pkg::*;
#(
   parameter int XY_SZ     = 3,
   parameter int OFFSET_SZ = 12,
   parameter int CNT_W     = 8
) (
   input  logic                 clk_ctrl,
   input  logic                 clk_ctrl_rst_low,
   input  logic [2*XY_SZ-1:0]   HsrcId,
   input  logic                 stream_in_TVALID,
   input  logic [31:0]          stream_in_TDATA,
   input  logic [3:0]           stream_in_TKEEP,
   input  logic                 stream_in_TLAST,
   output logic                 stream_in_TREADY,
   output logic                 stream_out_TVALID,
   output logic [31:0]          stream_out_TDATA,
   output logic [3:0]           stream_out_TKEEP,
   output logic                 stream_out_TLAST,
   input  logic                 stream_out_TREADY,
   output logic                 mem_valid,
   output logic [31:0]          mem_addr,
   output logic [31:0]          mem_wdata,
   output logic [3:0]           mem_wstrb,
   input  logic                 mem_ready,
   input  logic [31:0]          mem_rdata,
   output logic                 resp_idle,
   output logic [CNT_W-1:0]     drop_cnt
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DATA  = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_MEM   = 3'd3;
   localparam logic [2:0] S_RSP_H = 3'd4;
   localparam logic [2:0] S_RSP_D = 3'd5;

   localparam int OFF_LO  = 2*XY_SZ;
   localparam int SRC_LO  = 2*XY_SZ + OFFSET_SZ;
   localparam int CODE_LO = 4*XY_SZ + OFFSET_SZ + 1;

   logic [2:0]           state_q, state_d;
   logic [2:0]           code_q, code_d;
   logic [2*XY_SZ-1:0]   src_q, src_d;
   logic [OFFSET_SZ-1:0] offset_q, offset_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [CNT_W-1:0]     drop_q;
   logic                 drop_inc;
   logic                 in_rdy_q;
   logic                 mem_valid_q;
   logic [31:0]          mem_addr_q, mem_wdata_q;
   logic [3:0]           mem_wstrb_q;
   logic                 beat;
   logic                 is_load;
   logic [2:0]           hdr_code;
   logic [2*XY_SZ-1:0]   hdr_src, hdr_dest;
   logic [OFFSET_SZ-1:0] hdr_offset;
   logic [31:0]          rsp_hdr;
   logic                 unused_keep;

   assign unused_keep = ^stream_in_TKEEP;

   assign beat       = stream_in_TVALID & in_rdy_q;
   assign is_load    = (code_q == MLOAD);
   assign hdr_code   = stream_in_TDATA[CODE_LO+2:CODE_LO];
   assign hdr_src    = stream_in_TDATA[SRC_LO+2*XY_SZ-1:SRC_LO];
   assign hdr_offset = stream_in_TDATA[SRC_LO-1:OFF_LO];
   assign hdr_dest   = stream_in_TDATA[2*XY_SZ-1:0];

   mem_rsp_fmt #(
      .XY_SZ     (XY_SZ),
      .OFFSET_SZ (OFFSET_SZ)
   ) u_fmt (
      .is_load_i (is_load),
      .self_id_i (HsrcId),
      .offset_i  (offset_q),
      .src_i     (src_q),
      .hdr_o     (rsp_hdr)
   );

   // Packet parser / transaction sequencer next-state logic
   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      src_d    = src_q;
      offset_d = offset_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      drop_inc = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (beat) begin
               code_d   = hdr_code;
               src_d    = hdr_src;
               offset_d = hdr_offset;
               if (stream_in_TLAST) begin
                  drop_inc = 1'b1;
               end else if (hdr_dest != HsrcId || !(hdr_code == MLOAD || hdr_code == MSTORE)) begin
                  drop_inc = 1'b1;
                  state_d  = S_DRAIN;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (beat) begin
               if (code_q == MSTORE) wdata_d = stream_in_TDATA;
               if (stream_in_TLAST) begin
                  state_d = S_MEM;
               end else begin
                  drop_inc = 1'b1;
                  state_d  = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (beat && stream_in_TLAST) state_d = S_IDLE;
         end
         S_MEM: begin
            if (mem_valid_q && mem_ready) begin
               rdata_d = is_load ? mem_rdata : 32'h0;
               state_d = S_RSP_H;
            end
         end
         S_RSP_H: begin
            if (stream_out_TREADY) state_d = S_RSP_D;
         end
         S_RSP_D: begin
            if (stream_out_TREADY) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, latched packet fields, input ready and saturating drop counter
   always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
      if (!clk_ctrl_rst_low) begin
         state_q  <= S_IDLE;
         code_q   <= '0;
         src_q    <= '0;
         offset_q <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         drop_q   <= '0;
         in_rdy_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         src_q    <= src_d;
         offset_q <= offset_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         in_rdy_q <= (state_d == S_IDLE) || (state_d == S_DATA) || (state_d == S_DRAIN);
         if (drop_inc && drop_q != {CNT_W{1'b1}}) drop_q <= drop_q + CNT_W'(1);
      end
   end

   // Memory request registers: issued the cycle after S_MEM entry, held until mem_ready
   always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
      if (!clk_ctrl_rst_low) begin
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
      end else if (state_q == S_MEM && !mem_valid_q) begin
         mem_valid_q <= 1'b1;
         mem_addr_q  <= {{(32-OFFSET_SZ){1'b0}}, offset_q[OFFSET_SZ-1:2], 2'b00};
         mem_wdata_q <= is_load ? 32'h0 : wdata_q;
         mem_wstrb_q <= is_load ? 4'h0 : 4'hF;
      end else if (mem_valid_q && mem_ready) begin
         mem_valid_q <= 1'b0;
      end
   end

   // Output decode from registered state
   always_comb begin
      stream_out_TDATA = 32'h0;
      if (state_q == S_RSP_H)      stream_out_TDATA = rsp_hdr;
      else if (state_q == S_RSP_D) stream_out_TDATA = rdata_q;
   end

   assign stream_in_TREADY  = in_rdy_q;
   assign stream_out_TVALID = (state_q == S_RSP_H) || (state_q == S_RSP_D);
   assign stream_out_TLAST  = (state_q == S_RSP_D);
   assign stream_out_TKEEP  = 4'hF;
   assign mem_valid         = mem_valid_q;
   assign mem_addr          = mem_addr_q;
   assign mem_wdata         = mem_wdata_q;
   assign mem_wstrb         = mem_wstrb_q;
   assign resp_idle         = (state_q == S_IDLE);
   assign drop_cnt          = drop_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

   logic        clk_ctrl = 1'b0;
   logic        clk_ctrl_rst_low;
   logic [5:0]  HsrcId;
   logic        stream_in_TVALID;
   logic [31:0] stream_in_TDATA;
   logic [3:0]  stream_in_TKEEP;
   logic        stream_in_TLAST;
   logic        stream_in_TREADY;
   logic        stream_out_TVALID;
   logic [31:0] stream_out_TDATA;
   logic [3:0]  stream_out_TKEEP;
   logic        stream_out_TLAST;
   logic        stream_out_TREADY;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        resp_idle;
   logic [7:0]  drop_cnt;

   int errors = 0;
   int checks = 0;

   // Hand-encoded headers, self id y=1 x=2
   localparam logic [31:0] H_STORE     = 32'h0E70_290A;
   localparam logic [31:0] H_LOAD      = 32'h0C70_290A;
   localparam logic [31:0] H_BAD_DEST  = 32'h0E70_290D;
   localparam logic [31:0] H_BAD_CODE  = 32'h0270_290A;
   localparam logic [31:0] R_ACK       = 32'h0228_291C;
   localparam logic [31:0] R_DATA      = 32'h0428_291C;

   always #5 clk_ctrl = ~clk_ctrl;

   mem_responder dut (
      .clk_ctrl          (clk_ctrl),
      .clk_ctrl_rst_low  (clk_ctrl_rst_low),
      .HsrcId            (HsrcId),
      .stream_in_TVALID  (stream_in_TVALID),
      .stream_in_TDATA   (stream_in_TDATA),
      .stream_in_TKEEP   (stream_in_TKEEP),
      .stream_in_TLAST   (stream_in_TLAST),
      .stream_in_TREADY  (stream_in_TREADY),
      .stream_out_TVALID (stream_out_TVALID),
      .stream_out_TDATA  (stream_out_TDATA),
      .stream_out_TKEEP  (stream_out_TKEEP),
      .stream_out_TLAST  (stream_out_TLAST),
      .stream_out_TREADY (stream_out_TREADY),
      .mem_valid         (mem_valid),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_wstrb         (mem_wstrb),
      .mem_ready         (mem_ready),
      .mem_rdata         (mem_rdata),
      .resp_idle         (resp_idle),
      .drop_cnt          (drop_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_beat(input logic [31:0] d, input logic last);
      int n;
      stream_in_TVALID = 1'b1;
      stream_in_TDATA  = d;
      stream_in_TLAST  = last;
      n = 0;
      while (!stream_in_TREADY && n < 100) begin
         @(negedge clk_ctrl);
         n++;
      end
      check("in_ready", {31'b0, stream_in_TREADY}, 32'h1);
      @(negedge clk_ctrl);
      stream_in_TVALID = 1'b0;
      stream_in_TLAST  = 1'b0;
   endtask

   task automatic do_mem(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] wdata, input int delay, input logic [31:0] rdata);
      int n;
      n = 0;
      while (!mem_valid && n < 100) begin
         @(negedge clk_ctrl);
         n++;
      end
      check({tag, "_mem_valid"}, {31'b0, mem_valid}, 32'h1);
      check({tag, "_mem_addr"}, mem_addr, addr);
      check({tag, "_mem_wstrb"}, {28'b0, mem_wstrb}, {28'b0, strb});
      if (strb == 4'hF) check({tag, "_mem_wdata"}, mem_wdata, wdata);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk_ctrl);
         check({tag, "_mem_hold"}, {31'b0, mem_valid}, 32'h1);
         check({tag, "_addr_hold"}, mem_addr, addr);
      end
      mem_ready = 1'b1;
      mem_rdata = rdata;
      @(negedge clk_ctrl);
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      check({tag, "_mem_drop"}, {31'b0, mem_valid}, 32'h0);
      check({tag, "_rsp_next"}, {31'b0, stream_out_TVALID}, 32'h1);
   endtask

   task automatic get_resp(input string tag, input logic [31:0] hdr, input logic [31:0] data, input int stall);
      int n;
      n = 0;
      while (!stream_out_TVALID && n < 100) begin
         @(negedge clk_ctrl);
         n++;
      end
      check({tag, "_hdr"}, stream_out_TDATA, hdr);
      check({tag, "_hdr_last"}, {31'b0, stream_out_TLAST}, 32'h0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk_ctrl);
         check({tag, "_hdr_stable"}, stream_out_TDATA, hdr);
         check({tag, "_in_blocked"}, {31'b0, stream_in_TREADY}, 32'h0);
      end
      stream_out_TREADY = 1'b1;
      @(negedge clk_ctrl);
      check({tag, "_data"}, stream_out_TDATA, data);
      check({tag, "_data_last"}, {31'b0, stream_out_TLAST}, 32'h1);
      check({tag, "_in_blocked_d"}, {31'b0, stream_in_TREADY}, 32'h0);
      @(negedge clk_ctrl);
      stream_out_TREADY = 1'b0;
      check({tag, "_done"}, {31'b0, stream_out_TVALID}, 32'h0);
      check({tag, "_idle"}, {31'b0, resp_idle}, 32'h1);
   endtask

   task automatic quiet(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         check({tag, "_no_mem"}, {31'b0, mem_valid}, 32'h0);
         check({tag, "_no_rsp"}, {31'b0, stream_out_TVALID}, 32'h0);
         @(negedge clk_ctrl);
      end
   endtask

   initial begin
      clk_ctrl_rst_low  = 1'b0;
      HsrcId            = 6'o12;
      stream_in_TVALID  = 1'b0;
      stream_in_TDATA   = 32'h0;
      stream_in_TKEEP   = 4'hF;
      stream_in_TLAST   = 1'b0;
      stream_out_TREADY = 1'b0;
      mem_ready         = 1'b0;
      mem_rdata         = 32'h0;

      // Reset values
      repeat (2) @(negedge clk_ctrl);
      check("rst_in_ready", {31'b0, stream_in_TREADY}, 32'h0);
      check("rst_out_valid", {31'b0, stream_out_TVALID}, 32'h0);
      check("rst_out_data", stream_out_TDATA, 32'h0);
      check("rst_out_last", {31'b0, stream_out_TLAST}, 32'h0);
      check("rst_out_keep", {28'b0, stream_out_TKEEP}, 32'hF);
      check("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
      check("rst_resp_idle", {31'b0, resp_idle}, 32'h1);
      check("rst_drop", {24'b0, drop_cnt}, 32'h0);
      clk_ctrl_rst_low = 1'b1;
      @(negedge clk_ctrl);
      check("post_rst_ready", {31'b0, stream_in_TREADY}, 32'h1);

      // MSTORE with 2-cycle header-to-mem_valid latency
      send_beat(H_STORE, 1'b0);
      send_beat(32'hDEAD_BEEF, 1'b1);
      check("st_lat_not_yet", {31'b0, mem_valid}, 32'h0);
      check("st_in_blocked", {31'b0, stream_in_TREADY}, 32'h0);
      @(negedge clk_ctrl);
      check("st_lat_now", {31'b0, mem_valid}, 32'h1);
      do_mem("st", 32'h0000_00A4, 4'hF, 32'hDEAD_BEEF, 0, 32'h0);
      get_resp("st", R_ACK, 32'h0, 0);

      // MLOAD with mem_ready after 5 cycles
      send_beat(H_LOAD, 1'b0);
      send_beat(32'h5555_AAAA, 1'b1);
      do_mem("ld", 32'h0000_00A4, 4'h0, 32'h0, 5, 32'h1234_5678);
      get_resp("ld", R_DATA, 32'h1234_5678, 0);

      // Backpressure on response header with a queued next request
      send_beat(H_LOAD, 1'b0);
      send_beat(32'h0, 1'b1);
      do_mem("bp", 32'h0000_00A4, 4'h0, 32'h0, 1, 32'hA5A5_0F0F);
      stream_in_TVALID = 1'b1;
      stream_in_TDATA  = H_STORE;
      stream_in_TLAST  = 1'b0;
      get_resp("bp", R_DATA, 32'hA5A5_0F0F, 10);
      check("bp_queued_ready", {31'b0, stream_in_TREADY}, 32'h1);
      send_beat(H_STORE, 1'b0);
      send_beat(32'h0BAD_CAFE, 1'b1);
      do_mem("bp2", 32'h0000_00A4, 4'hF, 32'h0BAD_CAFE, 0, 32'h0);
      get_resp("bp2", R_ACK, 32'h0, 0);
      check("drop_none", {24'b0, drop_cnt}, 32'h0);

      // Wrong destination
      send_beat(H_BAD_DEST, 1'b0);
      send_beat(32'h1111_1111, 1'b1);
      quiet("dest", 4);
      check("dest_drop", {24'b0, drop_cnt}, 32'h1);
      check("dest_idle", {31'b0, resp_idle}, 32'h1);

      // 3-beat MLOAD
      send_beat(H_LOAD, 1'b0);
      send_beat(32'h0000_0001, 1'b0);
      send_beat(32'h0000_0002, 1'b1);
      quiet("long", 4);
      check("long_drop", {24'b0, drop_cnt}, 32'h2);

      // Header-only MSTORE
      send_beat(H_STORE, 1'b1);
      quiet("honly", 3);
      check("honly_drop", {24'b0, drop_cnt}, 32'h3);

      // Unsupported code
      send_beat(H_BAD_CODE, 1'b0);
      send_beat(32'h0000_0003, 1'b1);
      quiet("code", 3);
      check("code_drop", {24'b0, drop_cnt}, 32'h4);

      // Saturation
      for (int i = 0; i < 251; i++) send_beat(H_STORE, 1'b1);
      check("sat_255", {24'b0, drop_cnt}, 32'hFF);
      for (int i = 0; i < 49; i++) send_beat(H_STORE, 1'b1);
      check("sat_hold", {24'b0, drop_cnt}, 32'hFF);

      // Asynchronous reset while in S_MEM
      send_beat(H_LOAD, 1'b0);
      send_beat(32'h0, 1'b1);
      @(negedge clk_ctrl);
      check("ar_mem_valid", {31'b0, mem_valid}, 32'h1);
      check("ar_busy", {31'b0, resp_idle}, 32'h0);
      #2;
      clk_ctrl_rst_low = 1'b0;
      #1;
      check("ar_mem_cleared", {31'b0, mem_valid}, 32'h0);
      check("ar_idle", {31'b0, resp_idle}, 32'h1);
      check("ar_no_rsp", {31'b0, stream_out_TVALID}, 32'h0);
      check("ar_drop_cleared", {24'b0, drop_cnt}, 32'h0);
      repeat (2) @(negedge clk_ctrl);
      clk_ctrl_rst_low = 1'b1;
      @(negedge clk_ctrl);
      send_beat(H_LOAD, 1'b0);
      send_beat(32'h0, 1'b1);
      do_mem("ar_ld", 32'h0000_00A4, 4'h0, 32'h0, 2, 32'hCAFE_F00D);
      get_resp("ar_ld", R_DATA, 32'hCAFE_F00D, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
